// File: rtl/mem_arbiter2.sv
// mem_arbiter2: shares one single-port RAM between requester A (CPU data
// port) and requester B (DMA / loader / refresh). One access per clock,
// round-robin or fixed priority on ties, an optional bounded bus lock for
// bursts, and a registered read-data return per requester.
//
// Lock FSM
//   state    | meaning
//   OWN_NONE | no locking owner, normal arbitration
//   OWN_A    | A holds the bus while it keeps requesting
//   OWN_B    | B holds the bus while it keeps requesting
module mem_arbiter2 #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0,
    parameter int MAX_LOCK   = 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_in,
    input  logic [DATA_W-1:0] ram_out
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_A    = 2'd1,
        OWN_B    = 2'd2
    } owner_e;

    localparam logic [8:0] MAX_LOCK_C = 9'(MAX_LOCK);

    owner_e            owner_q;
    logic [7:0]        lock_cnt_q;
    logic              last_win_b_q;   // 1: B took the most recent grant
    logic              force_other_q;  // forced lock release: other port wins next tie
    logic              a_rvalid_q;
    logic              b_rvalid_q;
    logic [DATA_W-1:0] a_rdata_q;
    logic [DATA_W-1:0] b_rdata_q;

    logic              gnt_a;
    logic              gnt_b;
    logic              tie_pick_b;
    logic              gnt_any;
    logic              gnt_lock;
    logic              gnt_is_owner;
    logic [8:0]        lock_cnt_d;
    logic              lock_expire;

    // Grant decision: lock owner first, then tie-break, nothing while in reset.
    always_comb begin
        gnt_a      = 1'b0;
        gnt_b      = 1'b0;
        tie_pick_b = 1'b0;
        if ((FIXED_PRIO == 0) || force_other_q) begin
            tie_pick_b = !last_win_b_q;
        end
        if (reset) begin
            if ((owner_q == OWN_A) && a_req) begin
                gnt_a = 1'b1;
            end else if ((owner_q == OWN_B) && b_req) begin
                gnt_b = 1'b1;
            end else if (a_req && b_req) begin
                gnt_a = !tie_pick_b;
                gnt_b = tie_pick_b;
            end else begin
                gnt_a = a_req;
                gnt_b = b_req;
            end
        end
    end

    // Lock bookkeeping for the access granted this cycle.
    always_comb begin
        gnt_any      = gnt_a | gnt_b;
        gnt_lock     = (gnt_a & a_lock) | (gnt_b & b_lock);
        gnt_is_owner = (gnt_a && (owner_q == OWN_A)) || (gnt_b && (owner_q == OWN_B));
        lock_cnt_d   = gnt_is_owner ? ({1'b0, lock_cnt_q} + 9'd1) : 9'd1;
        lock_expire  = (lock_cnt_d >= MAX_LOCK_C);
    end

    // RAM pins follow the granted port; A's inputs are parked there when idle.
    always_comb begin
        ram_load    = (gnt_a & a_we) | (gnt_b & b_we);
        ram_address = gnt_b ? b_addr  : a_addr;
        ram_in      = gnt_b ? b_wdata : a_wdata;
    end

    // Lock FSM, last-winner memory and lock grant counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            owner_q       <= OWN_NONE;
            lock_cnt_q    <= 8'd0;
            last_win_b_q  <= 1'b1;
            force_other_q <= 1'b0;
        end else begin
            force_other_q <= 1'b0;
            if (gnt_any) begin
                last_win_b_q <= gnt_b;
            end
            if (gnt_any && gnt_lock) begin
                if (lock_expire) begin
                    // Burst hit its limit: drop the lock and hand the next tie over.
                    owner_q       <= OWN_NONE;
                    lock_cnt_q    <= 8'd0;
                    force_other_q <= 1'b1;
                end else begin
                    owner_q    <= gnt_a ? OWN_A : OWN_B;
                    lock_cnt_q <= lock_cnt_d[7:0];
                end
            end else begin
                // Either no grant (owner stopped requesting) or an unlocked access.
                owner_q    <= OWN_NONE;
                lock_cnt_q <= 8'd0;
            end
        end
    end

    // Registered read return: one rvalid pulse per read grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
            a_rdata_q  <= '0;
            b_rdata_q  <= '0;
        end else begin
            a_rvalid_q <= gnt_a & ~a_we;
            b_rvalid_q <= gnt_b & ~b_we;
            if (gnt_a && !a_we) begin
                a_rdata_q <= ram_out;
            end
            if (gnt_b && !b_we) begin
                b_rdata_q <= ram_out;
            end
        end
    end

    assign a_gnt    = gnt_a;
    assign b_gnt    = gnt_b;
    assign a_rvalid = a_rvalid_q;
    assign b_rvalid = b_rvalid_q;
    assign a_rdata  = a_rdata_q;
    assign b_rdata  = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter2.sv
// Directed bench for mem_arbiter2 with a behavioural 16K x 16 RAM.
// Inputs change 1 time unit after a rising edge; combinational grants are
// checked 2 units later, registered outputs 1 unit after the next edge.
module tb_mem_arbiter2;

    localparam int AW = 14;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, a_lock;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_gnt, a_rvalid;
    logic [DW-1:0] a_rdata;
    logic          b_req, b_we, b_lock;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_gnt, b_rvalid;
    logic [DW-1:0] b_rdata;
    logic          ram_load;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_in;
    logic [DW-1:0] ram_out;

    logic [DW-1:0] mem [0:16383];

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter2 #(
        .ADDR_W(AW), .DATA_W(DW), .FIXED_PRIO(0), .MAX_LOCK(4)
    ) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_load(ram_load), .ram_address(ram_address), .ram_in(ram_in), .ram_out(ram_out)
    );

    function automatic logic [DW-1:0] pat(input logic [AW-1:0] ad);
        return {2'b00, ad} ^ 16'hA5A5;
    endfunction

    assign ram_out = mem[ram_address];

    // RAM model: preloaded with an address pattern, written on rising edges.
    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = pat(14'(i));
        forever begin
            @(posedge clk);
            if (ram_load) mem[ram_address] = ram_in;
        end
    end

    task automatic idle_inputs();
        a_req = 1'b0; a_we = 1'b0; a_lock = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_lock = 1'b0; b_addr = '0; b_wdata = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0; a_req = 1'b1; b_req = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #2;
            total_cnt++;
            if ({a_gnt, b_gnt, ram_load} !== 3'b000)
                $display("FAIL reset_gnt c%0d: got %b expected 000", i, {a_gnt, b_gnt, ram_load});
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if ({a_rvalid, b_rvalid, a_rdata, b_rdata} !== 34'd0)
                $display("FAIL reset_regs c%0d: got rv=%b%b ad=%h bd=%h expected zeros",
                         i, a_rvalid, b_rvalid, a_rdata, b_rdata);
            else pass_cnt++;
        end
        reset = 1'b1;
        idle_inputs();
    endtask

    task automatic test_write_read();
        a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0005; a_wdata = 16'h1234;
        #2;
        total_cnt++;
        if ({a_gnt, b_gnt, ram_load, ram_address, ram_in} !== {3'b101, 14'h0005, 16'h1234})
            $display("FAIL wr_drive: got g=%b%b ld=%b ad=%h d=%h expected 10 1 0005 1234",
                     a_gnt, b_gnt, ram_load, ram_address, ram_in);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({a_rvalid, b_rvalid} !== 2'b00)
            $display("FAIL wr_no_rvalid: got %b expected 00", {a_rvalid, b_rvalid});
        else pass_cnt++;
        a_we = 1'b0;
        #2;
        total_cnt++;
        if ({a_gnt, b_gnt, ram_load} !== 3'b100)
            $display("FAIL rd_drive: got %b expected 100", {a_gnt, b_gnt, ram_load});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({a_rvalid, b_rvalid, a_rdata} !== {2'b10, 16'h1234})
            $display("FAIL rd_return: got rv=%b%b d=%h expected 10 1234", a_rvalid, b_rvalid, a_rdata);
        else pass_cnt++;
        idle_inputs();
        @(posedge clk); #1;
        total_cnt++;
        if ({a_rvalid, a_rdata} !== {1'b0, 16'h1234})
            $display("FAIL rd_single_pulse: got rv=%b d=%h expected 0 1234", a_rvalid, a_rdata);
        else pass_cnt++;
    endtask

    task automatic test_round_robin();
        int na = 0;
        int nb = 0;
        int rva = 0;
        int rvb = 0;
        logic exp_b;
        reset = 1'b0; idle_inputs();
        @(posedge clk); #1;
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            a_req = 1'b1; b_req = 1'b1;
            a_addr = 14'(32'h100 + na);
            b_addr = 14'(32'h200 + nb);
            exp_b = ((i % 2) == 1);
            #2;
            total_cnt++;
            if ({a_gnt, b_gnt} !== {!exp_b, exp_b})
                $display("FAIL rr_gnt c%0d: got %b%b expected %b%b", i, a_gnt, b_gnt, !exp_b, exp_b);
            else pass_cnt++;
            @(posedge clk); #1;
            rva += int'(a_rvalid);
            rvb += int'(b_rvalid);
            total_cnt++;
            if (exp_b) begin
                if ({a_rvalid, b_rvalid, b_rdata} !== {2'b01, pat(b_addr)})
                    $display("FAIL rr_ret c%0d: got rv=%b%b d=%h expected 01 %h",
                             i, a_rvalid, b_rvalid, b_rdata, pat(b_addr));
                else pass_cnt++;
                nb++;
            end else begin
                if ({a_rvalid, b_rvalid, a_rdata} !== {2'b10, pat(a_addr)})
                    $display("FAIL rr_ret c%0d: got rv=%b%b d=%h expected 10 %h",
                             i, a_rvalid, b_rvalid, a_rdata, pat(a_addr));
                else pass_cnt++;
                na++;
            end
        end
        idle_inputs();
        @(posedge clk); #1;
        rva += int'(a_rvalid);
        rvb += int'(b_rvalid);
        total_cnt++;
        if (rva != 3 || rvb != 3)
            $display("FAIL rr_pulse_count: got a=%0d b=%0d expected 3 3", rva, rvb);
        else pass_cnt++;
    endtask

    task automatic test_lock_burst();
        int nb = 0;
        logic exp_b;
        for (int k = 0; k < 7; k++) begin
            a_req = 1'b1; a_we = 1'b0; a_lock = 1'b0; a_addr = 14'h0040;
            b_req = 1'b1; b_we = 1'b1; b_lock = (k < 6);
            b_addr  = 14'(32'h300 + nb);
            b_wdata = 16'(32'hB000 + nb);
            exp_b = ((k >= 1) && (k <= 4)) || (k == 6);
            #2;
            total_cnt++;
            if ({a_gnt, b_gnt, ram_load} !== {!exp_b, exp_b, exp_b})
                $display("FAIL lock_gnt c%0d: got %b%b ld=%b expected %b%b ld=%b",
                         k, a_gnt, b_gnt, ram_load, !exp_b, exp_b, exp_b);
            else pass_cnt++;
            if (exp_b) begin
                total_cnt++;
                if ({ram_address, ram_in} !== {b_addr, b_wdata})
                    $display("FAIL lock_wr c%0d: got %h %h expected %h %h",
                             k, ram_address, ram_in, b_addr, b_wdata);
                else pass_cnt++;
                nb++;
            end
            @(posedge clk); #1;
            total_cnt++;
            if ({a_rvalid, b_rvalid} !== {!exp_b, 1'b0})
                $display("FAIL lock_rv c%0d: got %b%b expected %b0", k, a_rvalid, b_rvalid, !exp_b);
            else pass_cnt++;
        end
        idle_inputs();
    endtask

    task automatic test_lock_drop();
        logic [5:0] ar = 6'b111101;
        logic [5:0] al = 6'b001101;
        logic [5:0] eb = 6'b100010;
        for (int k = 0; k < 6; k++) begin
            a_req = ar[k]; a_lock = al[k]; a_we = 1'b0; a_addr = 14'h0060;
            b_req = 1'b1;  b_lock = 1'b0;  b_we = 1'b0; b_addr = 14'h0061;
            #2;
            total_cnt++;
            if ({a_gnt, b_gnt} !== {!eb[k], eb[k]})
                $display("FAIL drop_gnt c%0d: got %b%b expected %b%b", k, a_gnt, b_gnt, !eb[k], eb[k]);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_lock();
        b_req = 1'b1; b_lock = 1'b1; b_we = 1'b0; b_addr = 14'h0050;
        #2;
        total_cnt++;
        if ({a_gnt, b_gnt} !== 2'b01)
            $display("FAIL rml_gnt: got %b%b expected 01", a_gnt, b_gnt);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({b_rvalid, b_rdata} !== {1'b1, pat(14'h0050)})
            $display("FAIL rml_ret: got %b %h expected 1 %h", b_rvalid, b_rdata, pat(14'h0050));
        else pass_cnt++;
        reset = 1'b0; a_req = 1'b1;
        #2;
        total_cnt++;
        if ({a_gnt, b_gnt, ram_load} !== 3'b000)
            $display("FAIL rml_rst_gnt: got %b expected 000", {a_gnt, b_gnt, ram_load});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({a_rvalid, b_rvalid, b_rdata} !== 18'd0)
            $display("FAIL rml_rst_regs: got rv=%b%b d=%h expected 00 0000", a_rvalid, b_rvalid, b_rdata);
        else pass_cnt++;
        reset = 1'b1;
        #2;
        total_cnt++;
        if ({a_gnt, b_gnt} !== 2'b10)
            $display("FAIL rml_post_tie: got %b%b expected 10", a_gnt, b_gnt);
        else pass_cnt++;
        @(posedge clk); #1;
        idle_inputs();
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [AW-1:0] adr [3];
        logic [DW-1:0] exp_d [3];
        adr[0] = 14'h0300; exp_d[0] = 16'hB000;
        adr[1] = 14'h0301; exp_d[1] = 16'hB001;
        adr[2] = 14'h0012; exp_d[2] = pat(14'h0012);
        for (int k = 0; k < 3; k++) begin
            a_req = 1'b1; a_we = 1'b0; a_addr = adr[k];
            #2;
            total_cnt++;
            if ({a_gnt, ram_address} !== {1'b1, adr[k]})
                $display("FAIL b2b_gnt c%0d: got %b %h expected 1 %h", k, a_gnt, ram_address, adr[k]);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if ({a_rvalid, a_rdata} !== {1'b1, exp_d[k]})
                $display("FAIL b2b_ret c%0d: got %b %h expected 1 %h", k, a_rvalid, a_rdata, exp_d[k]);
            else pass_cnt++;
        end
        idle_inputs();
        @(posedge clk); #1;
        total_cnt++;
        if (a_rvalid !== 1'b0)
            $display("FAIL b2b_end: got %b expected 0", a_rvalid);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        test_reset();
        test_write_read();
        test_round_robin();
        test_lock_burst();
        test_lock_drop();
        test_reset_mid_lock();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
